// File: rtl/date_key_ctrl.sv
// Date-set front end: synchronizes and debounces the mode/shift/add keys, sequences the
// year/month/day set states, and drives the date counter's enable/shift/add controls.
module date_key_ctrl #(
  parameter int unsigned DEB_TICKS = 4,
  parameter int unsigned RPT_DLY   = 8,
  parameter int unsigned RPT_PER   = 2,
  parameter int unsigned TIMEOUT   = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       key_mode,
  input  logic       key_shift,
  input  logic       key_add,
  output logic       set_date_en,
  output logic       set_date_shift,
  output logic       set_date_add,
  output logic [1:0] field
);

  localparam int unsigned DW = $clog2(DEB_TICKS + 1);
  localparam int unsigned RW = $clog2(RPT_DLY + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  localparam logic [DW-1:0] DebLast   = DW'(DEB_TICKS - 1);
  localparam logic [RW-1:0] RptLast   = RW'(RPT_DLY - 1);
  localparam logic [RW-1:0] RptReload = RW'(RPT_DLY - RPT_PER);
  localparam logic [TW-1:0] ToLast    = TW'(TIMEOUT - 1);

  localparam int KeyMode  = 0;
  localparam int KeyShift = 1;
  localparam int KeyAdd   = 2;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StYear  = 2'd1,
    StMonth = 2'd2,
    StDay   = 2'd3
  } state_e;

  logic [2:0]    w_keys;
  logic [2:0]    r_sync1, r_sync2;
  logic [2:0]    r_deb_lvl, w_deb_lvl_nxt;
  logic [2:0]    r_lvl_dly;
  logic [2:0]    w_press;
  logic [DW-1:0] r_deb_cnt     [3];
  logic [DW-1:0] w_deb_cnt_nxt [3];

  state_e        r_state, w_state_nxt;
  logic          r_shift, w_shift_nxt;
  logic          r_add, w_add_nxt;
  logic [TW-1:0] r_to_cnt, w_to_nxt;
  logic [RW-1:0] r_rpt_cnt, w_rpt_nxt;
  logic          r_rpt_arm, w_arm_nxt;
  logic          w_rpt_fire;

  assign w_keys = {key_add, key_shift, key_mode};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_deb_lvl <= '0;
      r_lvl_dly <= '0;
      for (int k = 0; k < 3; k++) r_deb_cnt[k] <= '0;
    end else begin
      r_sync1   <= w_keys;
      r_sync2   <= r_sync1;
      r_deb_lvl <= w_deb_lvl_nxt;
      r_lvl_dly <= r_deb_lvl;
      for (int k = 0; k < 3; k++) r_deb_cnt[k] <= w_deb_cnt_nxt[k];
    end
  end

  // A level flips only after DEB_TICKS consecutive disagreeing tick samples.
  always_comb begin
    w_deb_lvl_nxt = r_deb_lvl;
    for (int k = 0; k < 3; k++) begin
      w_deb_cnt_nxt[k] = r_deb_cnt[k];
      if (tick) begin
        if (r_sync2[k] != r_deb_lvl[k]) begin
          if (r_deb_cnt[k] == DebLast) begin
            w_deb_lvl_nxt[k] = ~r_deb_lvl[k];
            w_deb_cnt_nxt[k] = '0;
          end else begin
            w_deb_cnt_nxt[k] = r_deb_cnt[k] + DW'(1);
          end
        end else begin
          w_deb_cnt_nxt[k] = '0;
        end
      end
    end
  end

  assign w_press = r_deb_lvl & ~r_lvl_dly;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_shift   <= 1'b0;
      r_add     <= 1'b0;
      r_to_cnt  <= '0;
      r_rpt_cnt <= '0;
      r_rpt_arm <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_add     <= w_add_nxt;
      r_to_cnt  <= w_to_nxt;
      r_rpt_cnt <= w_rpt_nxt;
      r_rpt_arm <= w_arm_nxt;
    end
  end

  // Events are resolved mode > shift > add; lower ones in the same cycle are dropped.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = 1'b0;
    w_add_nxt   = 1'b0;
    w_to_nxt    = r_to_cnt;
    w_rpt_nxt   = r_rpt_cnt;
    w_arm_nxt   = r_rpt_arm;
    w_rpt_fire  = 1'b0;
    if (r_state == StIdle) begin
      w_to_nxt  = '0;
      w_rpt_nxt = '0;
      w_arm_nxt = 1'b0;
      if (w_press[KeyMode]) w_state_nxt = StYear;
    end else if (w_press[KeyMode]) begin
      w_state_nxt = StIdle;
      w_to_nxt    = '0;
      w_rpt_nxt   = '0;
      w_arm_nxt   = 1'b0;
    end else if (w_press[KeyShift]) begin
      w_shift_nxt = 1'b1;
      w_to_nxt    = '0;
      w_rpt_nxt   = '0;
      w_arm_nxt   = 1'b0;
      case (r_state)
        StYear:  w_state_nxt = StMonth;
        StMonth: w_state_nxt = StDay;
        StDay:   w_state_nxt = StYear;
        default: w_state_nxt = StIdle;
      endcase
    end else if (w_press[KeyAdd]) begin
      w_add_nxt = 1'b1;
      w_to_nxt  = '0;
      w_rpt_nxt = '0;
      w_arm_nxt = 1'b1;
    end else begin
      if (r_rpt_arm && r_deb_lvl[KeyAdd]) begin
        if (tick) begin
          if (r_rpt_cnt == RptLast) begin
            w_rpt_fire = 1'b1;
            w_rpt_nxt  = RptReload;
          end else begin
            w_rpt_nxt = r_rpt_cnt + RW'(1);
          end
        end
      end else begin
        w_arm_nxt = 1'b0;
        w_rpt_nxt = '0;
      end
      if (w_rpt_fire) begin
        w_add_nxt = 1'b1;
        w_to_nxt  = '0;
      end else if (tick) begin
        if (r_to_cnt == ToLast) begin
          w_state_nxt = StIdle;
          w_to_nxt    = '0;
          w_rpt_nxt   = '0;
          w_arm_nxt   = 1'b0;
        end else begin
          w_to_nxt = r_to_cnt + TW'(1);
        end
      end
    end
  end

  assign field          = r_state;
  assign set_date_en    = (r_state != StIdle);
  assign set_date_shift = r_shift;
  assign set_date_add   = r_add;

endmodule

// File: doc/date_key_ctrl.md
# date_key_ctrl

Front-end controller for the date-setting datapath. It synchronizes and debounces three raw push-buttons (mode, shift, add) and sequences the date-set state machine. It drives the `set_date_en`, `set_date_shift` and `set_date_add` controls consumed by the date counter block, and supports auto-repeat on a held add key and an inactivity timeout. It sits between the board key pins and the date counter, alongside the time-setting front end.

## Interface
Parameters:
- `DEB_TICKS`, default 4: consecutive `tick` samples a synchronized key must hold a new level before the debounced level changes.
- `RPT_DLY`, default 8: ticks the add key must stay held after its press before auto-repeat starts.
- `RPT_PER`, default 2: ticks between auto-repeat add pulses.
- `TIMEOUT`, default 32: ticks without any key press event before set mode exits automatically.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low; clock is `clk`.
- `tick` in 1: one-`clk`-wide time-base strobe; it is the only sampling point for debounce, repeat and timeout.
- `key_mode` in 1: raw mode button, active-high, asynchronous to `clk`.
- `key_shift` in 1: raw field-select button, active-high, asynchronous.
- `key_add` in 1: raw increment button, active-high, asynchronous.
- `set_date_en` out 1: high while in any SET state.
- `set_date_shift` out 1: one-cycle pulse that advances the field in the date counter.
- `set_date_add` out 1: one-cycle pulse that increments the selected field.
- `field` out 2: selected field; 0 = none, 1 = year, 2 = month, 3 = day.

## Operation
Key conditioning:
- Each key passes through a 2-flop synchronizer.
- A per-key counter (width `clog2(DEB_TICKS+1)`) is handled on each `tick`:
  - If the synchronized value differs from the debounced level, the counter increments.
  - Otherwise the counter clears.
  - When the counter reaches `DEB_TICKS`, the debounced level flips and the counter clears.
- Press event: debounced level 0→1, one `clk` wide. Release produces no event.

State machine (states IDLE, SET_YEAR, SET_MONTH, SET_DAY):
- IDLE + mode event → SET_YEAR.
- SET_* + mode event → IDLE.
- SET_YEAR, SET_MONTH and SET_DAY + shift event → next state in the cycle year→month→day→year. Each such transition emits one `set_date_shift` pulse.
- SET_* + add event → one `set_date_add` pulse; state unchanged.
- Shift and add events in IDLE are ignored; no pulse is emitted.
- Timeout: in SET_*, a tick counter increments on each `tick` and saturates at `TIMEOUT`.
  - Any press event clears it, as does any auto-repeat pulse.
  - Reaching `TIMEOUT` → IDLE.
- `field` = 1/2/3 in SET_YEAR/MONTH/DAY, and 0 in IDLE.
- `set_date_en` = (`field` != 0).

Priority and corner cases:
- Simultaneous events in one cycle: mode > shift > add. Only the highest-priority event is acted on; the others are discarded, not queued.
- A timeout and a press event in the same cycle: the press wins and the timeout counter clears.
- Entering SET_YEAR does not emit `set_date_shift`. The downstream counter selects year on enable.

Auto-repeat:
- Active only in SET_*, and only while the debounced add level stays high.
- A repeat counter clears on the add press event and counts ticks.
- At count `RPT_DLY`, emit `set_date_add` and reload so the next pulse fires `RPT_PER` ticks later. This continues while add is held.
- Debounced add falling, a mode or shift event, or exit to IDLE stops repeat and clears the counter.

Reset:
- All outputs go to 0 and the state goes to IDLE.
- Synchronizers, debounced levels and all counters clear.
- Reset asserted mid-set or mid-repeat aborts immediately. No pulse is emitted on release.

## Timing
- Outputs are registered. A pulse appears in the cycle after the press event cycle.
- Press-to-pulse latency: 2 `clk` (sync) + `DEB_TICKS` ticks + 2 `clk`.
- `set_date_en` and `field` change in the same cycle as the corresponding `set_date_shift` pulse, or, on mode entry and exit, the cycle after the event.
- `set_date_shift` and `set_date_add` are never asserted in the same cycle.
- At most one `set_date_add` pulse is emitted per `tick` period.
- A bounce shorter than `DEB_TICKS` ticks never changes the debounced level.

## Test plan
- **Reset and entry:** hold `key_mode` high for 6 ticks (`DEB_TICKS`=4). Require exactly one transition to SET_YEAR: `field`=1 and `set_date_en`=1, with no shift or add pulse. Assert `rst_n` low mid-state; require all outputs 0 in the same cycle.
- **Debounce:** toggle `key_add` every 2 ticks for 20 ticks while in SET_YEAR. Require 0 `set_date_add` pulses. A clean 5-tick press must give exactly 1 pulse.
- **Field cycle:** from SET_YEAR, apply 4 clean shift presses. Require `field` to go 2, 3, 1, 2, with 4 one-cycle `set_date_shift` pulses. A mode press then gives `field`=0.
- **Auto-repeat:** in SET_DAY, hold add for 20 ticks past debounce (`RPT_DLY`=8, `RPT_PER`=2). Require pulses at ticks 0, 8, 10, 12, 14, 16, 18, 20 (8 pulses total). On release, pulses stop.
- **Timeout:** enter SET_MONTH and press nothing. Require IDLE (`field`=0) exactly on tick 32. A press on tick 31 restarts the count.
- **Priority:** mode and shift debounced in the same cycle while in SET_YEAR. Require IDLE and no `set_date_shift`. Shift and add together in SET_YEAR: require a shift pulse only, then `field`=2.
